// File: rtl/seq_11001_tx.sv
// Serial frame transmitter: sync word 11001, payload MSB first, optional parity, then an idle gap.
// Optional parity bit after the payload is compiled in when SEQ_TX_PARITY_EN is defined.
module seq_11001_tx #(
  parameter int W   = 8,
  parameter int GAP = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         sync_out,
  output logic         busy
);

  localparam int MAXC = (W > 5) ? ((W > GAP) ? W : GAP) : ((GAP > 5) ? GAP : 5);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [4:0]    SYNC_WORD = 5'b11001;
  localparam logic [CW-1:0] SYNC_LAST = CW'(4);
  localparam logic [CW-1:0] DATA_LAST = CW'(W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP > 0) ? GAP - 1 : 0);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  shreg, shreg_n;
  logic          dout_n, dout_valid_n, sync_out_n, busy_n, in_ready_n;
`ifdef SEQ_TX_PARITY_EN
  logic          par, par_n;
`endif

  // Next-state logic; outputs are then decoded from the next state so that
  // every output is a flop reflecting the bit of the current cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
`ifdef SEQ_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_n = S_SYNC;
          cnt_n   = SYNC_LAST;
          shreg_n = in_data;
`ifdef SEQ_TX_PARITY_EN
          par_n   = ^in_data;
`endif
        end
      end
      S_SYNC: begin
        if (cnt == '0) begin
          state_n = S_DATA;
          cnt_n   = DATA_LAST;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_DATA: begin
        shreg_n = shreg << 1;
        if (cnt == '0) begin
`ifdef SEQ_TX_PARITY_EN
          state_n = S_PAR;
`else
          if (GAP > 0) begin
            state_n = S_GAP;
            cnt_n   = GAP_LAST;
          end else begin
            state_n = S_IDLE;
          end
`endif
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        if (GAP > 0) begin
          state_n = S_GAP;
          cnt_n   = GAP_LAST;
        end else begin
          state_n = S_IDLE;
        end
      end
`endif
      S_GAP: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    dout_n       = 1'b0;
    dout_valid_n = 1'b0;
    sync_out_n   = 1'b0;
    unique case (state_n)
      S_SYNC: begin
        dout_n       = SYNC_WORD[cnt_n[2:0]];
        dout_valid_n = 1'b1;
        sync_out_n   = (cnt_n == '0);
      end
      S_DATA: begin
        dout_n       = shreg_n[W-1];
        dout_valid_n = 1'b1;
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        dout_n       = par_n;
        dout_valid_n = 1'b1;
      end
`endif
      default: ;
    endcase
    busy_n     = (state_n != S_IDLE);
    in_ready_n = (state_n == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
`ifdef SEQ_TX_PARITY_EN
      par        <= 1'b0;
`endif
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      sync_out   <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
`ifdef SEQ_TX_PARITY_EN
      par        <= par_n;
`endif
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      sync_out   <= sync_out_n;
      busy       <= busy_n;
      in_ready   <= in_ready_n;
    end
  end

endmodule

// File: doc/seq_11001_tx.md
# seq_11001_tx

Serial frame transmitter, the producer side of the 11001 sync-word link. Accepts a parallel payload word over a valid/ready handshake and emits it one bit per clock as: the 5-bit sync word 11001, then the payload MSB first, an optional parity bit, and an inter-frame gap. The serial output drives the overlapping Mealy 11001 detector at the receiving end. It also drives the loopback benches for that detector.

## Interface
- `W`, default 8: payload width in bits, minimum 1.
- `GAP`, default 2: idle cycles after each frame, minimum 0. During the gap `dout`=0 and `dout_valid`=0.

- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous reset, active-high. One clock domain only.
- `in_valid`, input, 1: a payload word is offered.
- `in_data`, input, W: the payload word.
- `in_ready`, output, 1: the transmitter can accept a word.
- `dout`, output, 1: serial bit stream.
- `dout_valid`, output, 1: `dout` carries a frame bit (sync, payload or parity).
- `sync_out`, output, 1: high during the cycle `dout` carries the last sync bit.
- `busy`, output, 1: a frame is in progress (any state except IDLE).

## Operation
- FSM states:
  - IDLE
  - SYNC: 5 cycles, bit counter 4 down to 0
  - DATA: W cycles
  - PAR: 1 cycle, only when parity is enabled
  - GAP: GAP cycles; skipped when GAP=0
- State transitions:
  - IDLE→SYNC on `in_valid & in_ready`. `in_data` is captured into the shift register on that edge.
  - SYNC→DATA after the 5th sync bit.
  - DATA→PAR (when enabled), otherwise →GAP, otherwise →IDLE.
  - PAR→GAP or IDLE.
  - GAP→IDLE after GAP cycles.
- SYNC bits, in order: 1,1,0,0,1. `sync_out`=1 only on the 5th sync bit.
- DATA: `dout` = shift-register MSB. The register shifts left once per DATA cycle.
- `in_ready` = (state == IDLE), registered-equivalent. It is never high while `busy`=1.
- `in_data` is ignored outside the accept edge. Changes to it during a frame do not affect the frame.
- `in_valid` held high in IDLE starts back-to-back frames.
- Payload may itself contain 11001. No bit stuffing is done; receiver framing is out of scope for this block.
- All outputs are driven from registers; there is no combinational path from inputs to outputs.

## Timing
- Reset values (outputs update on the first edge with `reset`=1):
  - state = IDLE
  - `dout`=0, `dout_valid`=0, `sync_out`=0, `busy`=0, `in_ready`=1
  - shift register and counters = 0
- Latency: with accept at edge N, the first sync bit appears on `dout` in cycle N+1 (after edge N). The 5th sync bit and `sync_out` appear in cycle N+5. Payload MSB appears in cycle N+6. Payload LSB appears in cycle N+5+W.
- Frame length in valid bits: L = 5 + W + P, where P=1 with parity enabled, else 0.
- Back-to-back period is 1 + L + GAP cycles: one mandatory IDLE accept cycle between frames.
- `dout_valid`=1 for exactly L consecutive cycles per frame. `dout`=0 whenever `dout_valid`=0.
- Reset mid-frame: the frame is aborted immediately. The outputs take their reset values in the cycle after the reset edge. No partial frame resumes afterwards.
- `reset` has priority over `in_valid` on the same edge: the word is not accepted.

## Configuration
- `SEQ_TX_PARITY_EN` defined:
  - The PAR state is compiled in. It emits one bit after the payload LSB: the even-parity bit, equal to the XOR of all W payload bits.
  - P=1.
- Not defined:
  - No PAR state and no parity logic.
  - DATA goes directly to GAP or IDLE; P=0.

## Test plan
- Reset, then W=8, GAP=2, no parity, `in_data`=8'hA5 offered for one cycle.
  - Required: `dout` = 1,1,0,0,1,1,0,1,0,0,1,0,1 over 13 cycles with `dout_valid`=1.
  - `sync_out`=1 on the 5th bit only.
  - Then 2 gap cycles with `dout`=0 and `dout_valid`=0, then `in_ready`=1.
- `in_valid` held high with words 8'h01 then 8'hFF.
  - Required: the frames are separated by exactly 2 gap + 1 idle cycles.
  - The second frame's payload is 8 ones.
  - `in_ready`=0 throughout each frame.
- Feed `dout` into the 11001 detector with `in_data`=8'h00 (frame 1,1,0,0,1,0,0,0,0,0,0,0,0).
  - Required: the detector output `y` is high exactly in the cycle `sync_out`=1.
- With `SEQ_TX_PARITY_EN`, `in_data`=8'h07.
  - Required: 14 valid bits, the last being 1 (three ones, so parity=1).
  - With 8'hA5 the last valid bit is 0.
- Assert `reset` during payload bit 3 of a frame.
  - Required: next cycle `dout`=0, `dout_valid`=0, `busy`=0, `in_ready`=1.
  - A new word accepted afterwards starts with a full 11001 sync.
- Change `in_data` every cycle during a frame.
  - Required: the transmitted payload equals the word captured at the accept edge.
